// File: rtl/clmul_seq.sv
// Iterative carry-less multiplier for CLMUL / CLMULH / CLMULR.
// Consumes BPC multiplier bits per cycle and returns one 32-bit word over a valid/ready channel.
module clmul_seq #(
    parameter int unsigned BPC = 4
) (
    input  logic        s_clk_i,
    input  logic        s_rst_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [1:0]  s_mode_i,
    input  logic [31:0] s_op1_i,
    input  logic [31:0] s_op2_i,
    input  logic        s_flush_i,
    output logic        s_valid_o,
    input  logic        s_ready_i,
    output logic [31:0] s_result_o,
    output logic        s_busy_o
);

    localparam int unsigned N  = 32 / BPC;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e        state_q;
    logic [63:0]   op1_q;
    logic [31:0]   op2_q;
    logic [1:0]    mode_q;
    logic [SW-1:0] step_q;
    logic [63:0]   acc_q;
    logic [63:0]   acc_d;
    logic [63:0]   pp;
    logic [31:0]   result_q;
    logic [31:0]   result_d;

    // op1 is pre-shifted and op2 consumed from the bottom, so the low BPC bits of op2_q
    // always line up with the current op1_q alignment.
    always_comb begin
        pp = '0;
        for (int k = 0; k < int'(BPC); k++) begin
            if (op2_q[k]) begin
                pp = pp ^ (op1_q << k);
            end
        end
        acc_d = acc_q ^ pp;
        case (mode_q)
            2'b00:   result_d = acc_d[31:0];
            2'b01:   result_d = acc_d[63:32];
            2'b10:   result_d = acc_d[62:31];
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state_q  <= StIdle;
            op1_q    <= '0;
            op2_q    <= '0;
            mode_q   <= '0;
            step_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (s_flush_i) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (s_valid_i) begin
                        op1_q   <= {32'b0, s_op1_i};
                        op2_q   <= s_op2_i;
                        mode_q  <= s_mode_i;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    acc_q  <= acc_d;
                    op1_q  <= op1_q << BPC;
                    op2_q  <= op2_q >> BPC;
                    step_q <= step_q + SW'(1);
                    if (step_q == SW'(N - 1)) begin
                        result_q <= result_d;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (s_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_ready_o  = (state_q == StIdle);
    assign s_valid_o  = (state_q == StDone);
    assign s_busy_o   = (state_q != StIdle);
    assign s_result_o = result_q;

endmodule

// File: tb/tb_clmul_seq.sv
// Scoreboard bench for clmul_seq: directed corner cases, then random ops with random
// response backpressure and sparse flushes, checked against a bitwise product model.
module tb_clmul_seq;

    localparam int unsigned BPC = 4;
    localparam int N = 32 / BPC;
    localparam int RAND_OPS = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'b00;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    clmul_seq #(.BPC(BPC)) dut (
        .s_clk_i    (clk),
        .s_rst_i    (rst),
        .s_valid_i  (in_valid),
        .s_ready_o  (in_ready),
        .s_mode_i   (mode),
        .s_op1_i    (op1),
        .s_op2_i    (op2),
        .s_flush_i  (flush),
        .s_valid_o  (out_valid),
        .s_ready_i  (out_ready),
        .s_result_o (result),
        .s_busy_o   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        int          acc_cyc;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    seen = 1'b0;
    bit    rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Full 64-bit carry-less product built bit by bit from the definition.
    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++)
                if (a[i] && b[j]) p[i+j] = ~p[i+j];
        case (m)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return p[62:31];
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: compare whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'h0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(N));
                    seen = 1'b1;
                end
                chk("result", result, sb[0].exp);
                chk("ready_in_done", 32'(in_ready), 32'h0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int n;
        item_t it;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        mode = m;
        op1 = a;
        op2 = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !flush && !rst) begin
                it.exp = exp;
                it.acc_cyc = cyc + 1;
                sb.push_back(it);
                break;
            end
            n++;
            if (n > 400) begin
                chk("accept_timeout", 32'(n), 32'h0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode = 2'($urandom);
        op1 = $urandom;
        op2 = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sb.size() == 0 && in_ready) && n < 400);
        if (n >= 400) begin
            chk("idle_timeout", 32'(n), 32'h0);
            sb.delete();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'h1);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int n;
        int k;
        logic [1:0]  m;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        chk("reset_result", result, 32'h0);

        issue(2'b00, 32'h3, 32'h3, 32'h0000_0005);
        wait_idle();
        issue(2'b00, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF);
        wait_idle();
        issue(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000);
        wait_idle();
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        wait_idle();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        wait_idle();
        issue(2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        wait_idle();
        issue(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        wait_idle();

        // Response backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        issue(2'b00, 32'h1234_5678, 32'h0000_00F1, model(2'b00, 32'h1234_5678, 32'h0000_00F1));
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_idle("bp_release");
        issue(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, model(2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D));
        wait_idle();

        // Flush at step 3, then reset at step 5; neither may produce a response.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk_idle("flush");
        repeat (N + 3) @(negedge clk);
        issue(2'b00, 32'h5, 32'h3, 32'h0000_000F);
        wait_idle();

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        chk("midrst_result", result, 32'h0);
        repeat (N + 3) @(negedge clk);
        issue(2'b00, 32'h5, 32'h3, 32'h0000_000F);
        wait_idle();

        // Random regression.
        rand_ready = 1'b1;
        for (int i = 0; i < RAND_OPS; i++) begin
            m = 2'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            issue(m, a, b, model(m, a, b));
            if ($urandom_range(0, 39) == 0) begin
                k = $urandom_range(0, N + 1);
                if (k > 0) begin
                    repeat (k) @(posedge clk);
                    #1;
                end
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
            wait_idle();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
